// File: rtl/match_reporter.sv
// Logs one {frame_id, offset, word} record per frame that hit the flagged IP into a small
// first-word-fall-through FIFO, with a saturating hit counter and a sticky overflow flag.
module match_reporter #(
    parameter int DEPTH    = 8,
    parameter int FRAME_W  = 8,
    parameter int OFFSET_W = 12
) (
    input  logic                          clk,
    input  logic                          n_rst,
    input  logic                          clear,
    input  logic                          match,
    input  logic [31:0]                   data_in,
    input  logic                          rd_en,
    input  logic                          ovf_clr,
    output logic [FRAME_W+OFFSET_W+31:0]  rd_data,
    output logic                          empty,
    output logic                          full,
    output logic [$clog2(DEPTH):0]        count,
    output logic                          overflow,
    output logic [15:0]                   hit_count,
    output logic                          irq
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int REC_W = FRAME_W + OFFSET_W + 32;

    logic [FRAME_W-1:0]  frame_id_q, frame_id_d;
    logic [OFFSET_W-1:0] offset_q, offset_d;
    logic                armed_q, armed_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                overflow_q, overflow_d;
    logic [15:0]         hit_count_q, hit_count_d;
    logic [REC_W-1:0]    mem [DEPTH];

    logic hit, pop, push_ok, drop;

    assign empty = (count_q == '0);
    assign full  = (count_q == CNT_W'(DEPTH));
    assign hit   = match & armed_q & ~clear;
    assign pop   = rd_en & ~empty;
    // When full, a same-cycle pop frees the slot the new record lands in.
    assign push_ok = hit & (~full | pop);
    assign drop    = hit & full & ~rd_en;

    always_comb begin
        frame_id_d  = frame_id_q;
        offset_d    = offset_q;
        armed_d     = armed_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        hit_count_d = hit_count_q;

        if (clear) begin
            frame_id_d = frame_id_q + 1'b1;
            offset_d   = '0;
            armed_d    = 1'b1;
        end else begin
            if (offset_q != '1) offset_d = offset_q + 1'b1;
            if (hit) armed_d = 1'b0;
        end

        if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)     rd_ptr_d = rd_ptr_q + 1'b1;

        case ({push_ok, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        if (drop)         overflow_d = 1'b1;
        else if (ovf_clr) overflow_d = 1'b0;

        if (hit && hit_count_q != 16'hFFFF) hit_count_d = hit_count_q + 1'b1;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            frame_id_q  <= '0;
            offset_q    <= '0;
            armed_q     <= 1'b1;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            hit_count_q <= '0;
        end else begin
            frame_id_q  <= frame_id_d;
            offset_q    <= offset_d;
            armed_q     <= armed_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            hit_count_q <= hit_count_d;
        end
    end

    // Storage needs no reset: the pointers and count define which entries are live.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr_q] <= {frame_id_q, offset_q, data_in};
    end

    assign rd_data   = empty ? '0 : mem[rd_ptr_q];
    assign count     = count_q;
    assign overflow  = overflow_q;
    assign hit_count = hit_count_q;
    assign irq       = ~empty;
endmodule

// File: tb/tb_match_reporter.sv
// Directed bench for match_reporter: stimulus pushes hand-computed records into a queue and
// a negedge monitor compares every popped head record against it.
module tb_match_reporter;
    logic        clk = 1'b0;
    logic        n_rst;
    logic        clear, match, rd_en, ovf_clr;
    logic [31:0] data_in;
    logic [51:0] rd_data;
    logic        empty, full, overflow, irq;
    logic [3:0]  count;
    logic [15:0] hit_count;

    int errors = 0;
    int checks = 0;
    logic [51:0] expq [$];

    match_reporter #(.DEPTH(8), .FRAME_W(8), .OFFSET_W(12)) dut (
        .clk(clk), .n_rst(n_rst), .clear(clear), .match(match), .data_in(data_in),
        .rd_en(rd_en), .ovf_clr(ovf_clr), .rd_data(rd_data), .empty(empty), .full(full),
        .count(count), .overflow(overflow), .hit_count(hit_count), .irq(irq)
    );

    always #5 clk = ~clk;

    function automatic logic [51:0] rec(input logic [7:0] f, input logic [11:0] o,
                                        input logic [31:0] d);
        return {f, o, d};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    task automatic cyc(input logic c, input logic m, input logic [31:0] d,
                       input logic r, input logic oc);
        clear = c; match = m; data_in = d; rd_en = r; ovf_clr = oc;
        @(posedge clk);
        #1;
        clear = 1'b0; match = 1'b0; rd_en = 1'b0; ovf_clr = 1'b0; data_in = '0;
    endtask

    // Monitor: the head record is consumed at the coming edge whenever rd_en is high and not empty.
    always @(negedge clk) begin
        if (n_rst && rd_en && !empty) begin
            if (expq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL pop: got %0h expected no record", rd_data);
            end else begin
                chk("pop", 64'(rd_data), 64'(expq.pop_front()));
            end
        end
    end

    initial begin
        n_rst = 1'b0; clear = 0; match = 0; rd_en = 0; ovf_clr = 0; data_in = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_empty", 64'(empty), 64'd1);
        chk("rst_full", 64'(full), 64'd0);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_rd_data", 64'(rd_data), 64'd0);
        chk("rst_irq", 64'(irq), 64'd0);
        n_rst = 1'b1;

        // Single hit: frame 1, offset 3
        cyc(1, 0, 0, 0, 0);
        repeat (3) cyc(0, 0, 0, 0, 0);
        expq.push_back(rec(8'h01, 12'h003, 32'hC0A80101));
        cyc(0, 1, 32'hC0A80101, 0, 0);
        chk("hit1_count", 64'(count), 64'd1);
        chk("hit1_irq", 64'(irq), 64'd1);
        chk("hit1_rd_data", 64'(rd_data), 64'(rec(8'h01, 12'h003, 32'hC0A80101)));
        chk("hit1_hits", 64'(hit_count), 64'd1);
        cyc(0, 1, 32'hC0A80101, 0, 0);
        chk("hit1_once", 64'(count), 64'd1);
        chk("hit1_hits2", 64'(hit_count), 64'd1);
        cyc(0, 0, 0, 1, 0);
        chk("hit1_empty", 64'(empty), 64'd1);

        // Clear and match together: no push; next match gets offset 0 in frame 2
        cyc(1, 1, 32'h11111111, 0, 0);
        chk("clrm_count", 64'(count), 64'd0);
        expq.push_back(rec(8'h02, 12'h000, 32'hAABBCCDD));
        cyc(0, 1, 32'hAABBCCDD, 0, 0);
        chk("clrm_count2", 64'(count), 64'd1);
        chk("clrm_hits", 64'(hit_count), 64'd2);
        cyc(0, 0, 0, 1, 0);

        // Fill: frames 3..10, each hit at offset 1
        for (int k = 0; k < 8; k++) begin
            cyc(1, 0, 0, 0, 0);
            cyc(0, 0, 0, 0, 0);
            expq.push_back(rec(8'(3 + k), 12'h001, 32'h10000000 + 32'(k)));
            cyc(0, 1, 32'h10000000 + 32'(k), 0, 0);
        end
        chk("fill_full", 64'(full), 64'd1);
        chk("fill_count", 64'(count), 64'd8);
        chk("fill_hits", 64'(hit_count), 64'd10);
        chk("fill_ovf", 64'(overflow), 64'd0);

        // Drop in frame 11
        cyc(1, 0, 0, 0, 0);
        cyc(0, 1, 32'hDEADBEEF, 0, 0);
        chk("drop_ovf", 64'(overflow), 64'd1);
        chk("drop_hits", 64'(hit_count), 64'd11);
        chk("drop_count", 64'(count), 64'd8);
        chk("drop_head", 64'(rd_data), 64'(rec(8'h03, 12'h001, 32'h10000000)));
        cyc(0, 0, 0, 0, 1);
        chk("ovf_clr", 64'(overflow), 64'd0);

        // Drop coinciding with ovf_clr in frame 12: set wins
        cyc(1, 0, 0, 0, 0);
        cyc(0, 1, 32'hBADBAD00, 0, 1);
        chk("ovf_setwins", 64'(overflow), 64'd1);
        chk("setwins_hits", 64'(hit_count), 64'd12);

        // Full with read in frame 13: head popped, new record at tail
        cyc(1, 0, 0, 0, 0);
        expq.push_back(rec(8'h0D, 12'h000, 32'h5555AAAA));
        cyc(0, 1, 32'h5555AAAA, 1, 0);
        chk("fullrd_count", 64'(count), 64'd8);
        chk("fullrd_full", 64'(full), 64'd1);
        chk("fullrd_hits", 64'(hit_count), 64'd13);
        chk("fullrd_head", 64'(rd_data), 64'(rec(8'h04, 12'h001, 32'h10000001)));

        // Drain
        for (int i = 0; i < 8; i++) begin
            cyc(0, 0, 0, 1, 0);
            chk("drain_count", 64'(count), 64'(7 - i));
        end
        chk("drain_empty", 64'(empty), 64'd1);
        chk("drain_irq", 64'(irq), 64'd0);
        chk("drain_rd_data", 64'(rd_data), 64'd0);
        cyc(0, 0, 0, 1, 0);
        chk("pop_empty_noop", 64'(count), 64'd0);

        // Push and pop while empty in frame 14: record kept
        cyc(1, 0, 0, 0, 0);
        expq.push_back(rec(8'h0E, 12'h000, 32'h12345678));
        cyc(0, 1, 32'h12345678, 1, 0);
        chk("pushpop_empty_count", 64'(count), 64'd1);
        chk("pushpop_empty_data", 64'(rd_data), 64'(rec(8'h0E, 12'h000, 32'h12345678)));

        // Mid-stream asynchronous reset
        n_rst = 1'b0;
        #2;
        chk("mid_rst_empty", 64'(empty), 64'd1);
        chk("mid_rst_count", 64'(count), 64'd0);
        chk("mid_rst_rd_data", 64'(rd_data), 64'd0);
        chk("mid_rst_hits", 64'(hit_count), 64'd0);
        chk("mid_rst_ovf", 64'(overflow), 64'd0);
        expq.delete();
        @(posedge clk);
        #1;
        n_rst = 1'b1;

        // Frame id wrap: 255 clears reach FF, the 256th wraps to 00
        repeat (255) cyc(1, 0, 0, 0, 0);
        expq.push_back(rec(8'hFF, 12'h000, 32'h000000A1));
        cyc(0, 1, 32'h000000A1, 0, 0);
        cyc(1, 0, 0, 0, 0);
        expq.push_back(rec(8'h00, 12'h000, 32'h000000A2));
        cyc(0, 1, 32'h000000A2, 0, 0);
        chk("wrap_count", 64'(count), 64'd2);
        chk("wrap_hits", 64'(hit_count), 64'd2);
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 1, 0);

        // Offset saturation in frame 1
        cyc(1, 0, 0, 0, 0);
        repeat (4100) cyc(0, 0, 0, 0, 0);
        expq.push_back(rec(8'h01, 12'hFFF, 32'h000000B0));
        cyc(0, 1, 32'h000000B0, 0, 0);
        chk("sat_rd_data", 64'(rd_data), 64'(rec(8'h01, 12'hFFF, 32'h000000B0)));
        cyc(0, 0, 0, 1, 0);
        chk("sat_empty", 64'(empty), 64'd1);

        chk("queue_drained", 64'(expq.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
